// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Also synchronises and edge-detects the Enter key for INPUT.
module control_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       halt,
    output logic       waiting,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        START  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD   = 4'd8,
        STORE  = 4'd9,
        ADD    = 4'd10,
        SUB    = 4'd11,
        INPUT  = 4'd12,
        JZ     = 4'd13,
        JPOS   = 4'd14,
        HALT   = 4'd15
    } state_t;

    state_t                 cur;
    state_t                 nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   synced;
    logic                   enter_edge;

    assign synced     = sync[SYNC_STAGES-1];
    assign enter_edge = synced & ~prev;
    assign state      = cur;

    // Enter synchroniser chain plus previous-value flop for rise detection
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], enter};
            prev <= synced;
        end
    end

    // State register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cur <= START;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state: decode dispatches to 8+opcode; illegal codes restart
    always_comb begin
        nxt = START;
        case (cur)
            START:  nxt = FETCH;
            FETCH:  nxt = DECODE;
            DECODE: nxt = state_t'({1'b1, IR75});
            LOAD, STORE, ADD, SUB, JZ, JPOS:
                    nxt = FETCH;
            INPUT:  nxt = enter_edge ? FETCH : INPUT;
            HALT:   nxt = HALT;
            default: nxt = START;
        endcase
    end

    // Datapath strobes decoded from state and accumulator flags
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = 2'b00;
        Aload   = 1'b0;
        Sub     = 1'b0;
        halt    = 1'b0;
        waiting = 1'b0;
        case (cur)
            FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            DECODE: Meminst = 1'b1;
            LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = 1'b1;
            end
            STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            SUB: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                Sub     = 1'b1;
            end
            INPUT: begin
                waiting = 1'b1;
                Asel    = 2'b01;
                Aload   = enter_edge;
            end
            JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            HALT: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed stimulus against an instruction-level
// reference model of the controller.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       clear;
    logic [2:0] IR75;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       halt;
    logic       waiting;
    logic [3:0] state;

    int checks = 0;
    int passes = 0;

    // model: phase 0=idle after reset, 1=fetch, 2=decode, 3=execute
    int         ph;
    logic [2:0] op;
    // enter values sampled at the last three clock edges (hist[0] newest)
    logic       hist [0:2];

    control_unit #(.SYNC_STAGES(2)) dut (
        .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
        .enter(enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
        .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
        .Sub(Sub), .halt(halt), .waiting(waiting), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic accept_now();
        return hist[1] && !hist[2];
    endfunction

    // expected strobes packed as
    // {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,halt,waiting}
    function automatic logic [10:0] exp_outs();
        logic ir, jm, pc, mi, mw, al, sb, hl, wt;
        logic [1:0] as;
        {ir, jm, pc, mi, mw, al, sb, hl, wt} = '0;
        as = 2'b00;
        if (ph == 1) begin
            ir = 1; pc = 1;
        end else if (ph == 2) begin
            mi = 1;
        end else if (ph == 3) begin
            if (op == 3'd0) begin mi = 1; as = 2'b10; al = 1; end
            if (op == 3'd1) begin mi = 1; mw = 1; end
            if (op == 3'd2) begin mi = 1; al = 1; end
            if (op == 3'd3) begin mi = 1; al = 1; sb = 1; end
            if (op == 3'd4) begin wt = 1; as = 2'b01; al = accept_now(); end
            if (op == 3'd5) begin jm = 1; pc = Aeq0; end
            if (op == 3'd6) begin jm = 1; pc = Apos; end
            if (op == 3'd7) hl = 1;
        end
        return {ir, jm, pc, mi, mw, as, al, sb, hl, wt};
    endfunction

    function automatic logic [3:0] exp_state();
        if (ph == 3) return 4'd8 + {1'b0, op};
        return ph[3:0];
    endfunction

    task automatic model_reset();
        ph = 0;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
    endtask

    // advance the model across one rising edge using the held inputs
    task automatic model_step();
        logic acc;
        acc = accept_now();
        if (!clear) begin
            model_reset();
        end else begin
            if (ph == 0) ph = 1;
            else if (ph == 1) ph = 2;
            else if (ph == 2) begin ph = 3; op = IR75; end
            else if (op == 3'd4) begin if (acc) ph = 1; end
            else if (op != 3'd7) ph = 1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = enter;
        end
    endtask

    task automatic check_now();
        chk("outs", {5'b0, IRload, JMPmux, PCload, Meminst, MemWr, Asel,
                     Aload, Sub, halt, waiting}, {5'b0, exp_outs()});
        chk("state", {12'b0, state}, {12'b0, exp_state()});
    endtask

    // called at a falling edge with inputs already driven
    task automatic run_cycle();
        #1;
        check_now();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        IR75 = 3'($urandom_range(0, 6));
        Aeq0 = 1'($urandom_range(0, 1));
        Apos = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) enter = ~enter;
    endtask

    initial begin
        clear = 1'b0; IR75 = 3'd0; Aeq0 = 0; Apos = 0; enter = 0;
        op = 3'd0;
        model_reset();
        #1;
        check_now();
        @(negedge clk);
        run_cycle();
        run_cycle();

        // release reset and walk into ADD, then clear asynchronously
        clear = 1'b1;
        IR75 = 3'd2;
        run_cycle();
        run_cycle();
        run_cycle();
        #1;
        check_now();
        #1;
        clear = 1'b0;
        model_reset();
        #1;
        check_now();
        @(posedge clk);
        model_step();
        @(negedge clk);
        clear = 1'b1;
        run_cycle();
        run_cycle();
        run_cycle();

        // random instruction stream with occasional reset pulses
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            clear = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if (!clear) model_reset();
            run_cycle();
        end

        // drive into HALT, bounded
        clear = 1'b1;
        for (int i = 0; i < 300 && !(ph == 3 && op == 3'd7); i++) begin
            randomize_inputs();
            IR75 = 3'd7;
            run_cycle();
        end
        #1;
        chk("halt_reached", {12'b0, state}, 16'd15);
        for (int i = 0; i < 25; i++) begin
            randomize_inputs();
            run_cycle();
        end
        chk("halt_held", {15'b0, halt}, 16'd1);

        // clear releases HALT
        #1;
        clear = 1'b0;
        model_reset();
        #1;
        check_now();
        @(negedge clk);
        clear = 1'b1;
        run_cycle();
        run_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Finite-state controller that sequences the 8-bit accumulator datapath through fetch, decode and execute for the eight-instruction set. It consumes the opcode field IR[7:5] and the accumulator status flags (Aeq0, Apos) from the datapath. It drives every datapath control strobe, and it synchronises and edge-detects the external Enter key for the INPUT instruction. It sits directly upstream of the datapath; together they form the complete processor.

## Interface
- SYNC_STAGES, 2, number of flip-flops in the Enter synchroniser (minimum 2).

- clk  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR75  in  3  opcode from instruction register.
- Aeq0  in  1  accumulator == 0.
- Apos  in  1  accumulator is positive (bit 7 == 0 and A != 0).
- enter  in  1  asynchronous Enter key, active-high.
- IRload  out  1  load instruction register.
- JMPmux  out  1  PC source: 0 = PC+1, 1 = IR[4:0].
- PCload  out  1  load program counter.
- Meminst  out  1  RAM address source: 0 = PC, 1 = IR[4:0].
- MemWr  out  1  write accumulator to RAM.
- Asel  out  2  accumulator input: 00 = adder/subtractor, 01 = input port, 10 = RAM, 11 unused (never driven).
- Aload  out  1  load accumulator.
- Sub  out  1  adder/subtractor mode: 0 = add, 1 = subtract.
- halt  out  1  high in HALT state.
- waiting  out  1  high in INPUT state until an Enter edge is accepted.
- state  out  4  current state code, for debug.

## Operation
- State codes:
  - START=0, FETCH=1, DECODE=2.
  - Execute states are 8+opcode: LOAD=8 (000), STORE=9 (001), ADD=10 (010), SUB=11 (011), INPUT=12 (100), JZ=13 (101), JPOS=14 (110), HALT=15 (111).
  - Codes 3–7 are illegal and go to START on the next edge.
- Transitions:
  - START→FETCH→DECODE→(8+IR75).
  - Every execute state except INPUT and HALT returns to FETCH after one cycle.
  - INPUT returns to FETCH only in the cycle an Enter edge is accepted.
  - HALT is absorbing until clear.
- Outputs are combinational from state plus flags. Any signal not listed for a state is 0.
  - START: all 0.
  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0.
  - DECODE: Meminst=1.
  - LOAD: Meminst=1, Asel=10, Aload=1.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Meminst=1, Asel=00, Sub=0, Aload=1.
  - SUB: Meminst=1, Asel=00, Sub=1, Aload=1.
  - INPUT: waiting=1; Asel=01 throughout; Aload=1 only in the edge-accept cycle.
  - JZ: JMPmux=1; PCload=Aeq0.
  - JPOS: JMPmux=1; PCload=Apos.
  - HALT: halt=1.
- Enter handling:
  - enter passes through a SYNC_STAGES-deep synchroniser, then a one-flop previous-value register.
  - An edge is defined as synced=1 and prev=0.
  - Edges outside INPUT are discarded, not queued.
  - A level already high on entry to INPUT does not count; a fresh rise is required.
- Reset (clear=0) takes effect immediately, regardless of clock:
  - state=START; synchroniser and prev flops cleared.
  - All outputs 0, including halt and waiting; state output reads 0.
  - Reset mid-instruction abandons it. No partial MemWr or Aload may occur after clear falls.

## Timing
- After clear deasserts: START for one cycle, then FETCH on the first edge.
- Instructions other than INPUT and HALT take exactly 3 cycles (FETCH, DECODE, EXEC).
- Datapath registers update on the edge that ends the asserting cycle:
  - IR and PC load at the end of FETCH.
  - A and RAM update at the end of EXEC.
- Jump: the PC holds IR[4:0] at the end of the JZ/JPOS cycle; the next FETCH reads the target.
- Aeq0/Apos are sampled combinationally in the JZ/JPOS cycle. They reflect A as updated by the previous instruction.
- Enter latency (SYNC_STAGES=2): if enter rises before edge k, Aload=1 in the cycle after edge k+1, and state is FETCH after edge k+2.
- Exactly one Aload pulse per accepted edge.

## Test plan
- Reset: hold clear=0 in mid-ADD state → all outputs 0, state=0 immediately (before the next clk edge). Release → state sequence 0,1,2.
- LOAD/ADD/SUB: IR75=000, then 010, then 011 → per instruction exactly one cycle each of FETCH (IRload=PCload=1), DECODE, and EXEC. EXEC shows Asel=10/00/00, Sub=0/0/1, Aload=1.
- STORE: IR75=001 → MemWr=1 and Meminst=1 for exactly one cycle; Aload never asserts.
- INPUT handshake:
  - Hold enter=1 before entering INPUT → waiting stays 1, no Aload.
  - Drop enter, then raise it → Aload=1 for one cycle, 2 cycles after the rise, then FETCH.
  - An enter pulse during FETCH is ignored.
- JZ/JPOS: with Aeq0=1, JZ gives PCload=1, JMPmux=1; with Aeq0=0, PCload=0 and next state is FETCH. Apos=1 vs 0 with JPOS gives the same pair of results.
- HALT: IR75=111 → halt=1 and state=15 for 20+ cycles despite enter toggling and flag changes; clear=0 returns to START.
